// File: rtl/trace_pkg.sv
// Shared constants and types for the dut: trace line parser.
package trace_pkg;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_U     = 8'h75;
    localparam logic [7:0] CH_T     = 8'h74;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [2:0] {PREFIX, SEP, DIGIT, EMIT, DISCARD} state_e;

    // Element 0 is the first expected character of "dut:".
    localparam logic [3:0][7:0] PREFIX_ROM = {CH_COLON, CH_T, CH_U, CH_D};

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction
endpackage

// File: rtl/trace_line_parser_if.sv
// Byte-in / record-out handshake bundle of the trace line parser.
interface trace_line_parser_if #(parameter int W = 2);
    logic         io_in_valid;
    logic         io_in_ready;
    logic [7:0]   io_in_bits;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_a;
    logic [W-1:0] io_out_b;
    logic [W-1:0] io_out_res;
    logic         io_out_mismatch;
    logic         io_err;

    modport slave (
        input  io_in_valid, io_in_bits, io_out_ready,
        output io_in_ready, io_out_valid, io_out_a, io_out_b, io_out_res,
               io_out_mismatch, io_err
    );
    modport master (
        output io_in_valid, io_in_bits, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_a, io_out_b, io_out_res,
               io_out_mismatch, io_err
    );
endinterface

// File: rtl/trace_line_parser_decimal_accumulator.sv
// Decimal digit accumulator with sticky range overflow and digit counting.
module decimal_accumulator #(
    parameter int W      = 2,
    parameter int MAXDIG = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [3:0]   digit_i,
    output logic [W+3:0] value_o,
    output logic         overflow_o,
    output logic         too_many_digits_o
);
    localparam int CW = $clog2(MAXDIG + 2);
    localparam int AW = W + 8;

    logic [W+3:0]  val_q, val_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base, nxt;

    // clear together with load starts a fresh field at the loaded digit.
    always_comb begin
        val_d = val_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        base  = clear_i ? '0 : AW'(val_q);
        nxt   = base * AW'(10) + AW'(digit_i);
        if (load_i) begin
            val_d = nxt[W+3:0];
            // Overflow is sticky: more digits can only grow the value.
            ovf_d = (clear_i ? 1'b0 : ovf_q) | (nxt > AW'((1 << W) - 1));
            cnt_d = clear_i ? CW'(1) : ((cnt_q > CW'(MAXDIG)) ? cnt_q : cnt_q + CW'(1));
        end else if (clear_i) begin
            val_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            val_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign value_o           = val_q;
    assign overflow_o        = ovf_q;
    assign too_many_digits_o = cnt_q > CW'(MAXDIG);
endmodule

// File: rtl/trace_line_parser.sv
// Parses "dut: a b out\n" trace lines into records and flags out != (a & b).
module trace_line_parser
    import trace_pkg::*;
#(
    parameter int W      = 2,
    parameter int MAXDIG = 3
) (
    input  logic                clock,
    input  logic                reset,
    trace_line_parser_if.slave  bus
);
    state_e       state_q, state_d;
    logic [1:0]   pidx_q, pidx_d;
    logic [1:0]   fidx_q, fidx_d;
    logic         sp_q, sp_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic         mm_q, mm_d;
    logic         err_q, err_d;

    logic         in_ready, fire, bad, field_ok;
    logic [7:0]   ch, dsub;
    logic         acc_clr, acc_ld, acc_ovf, acc_many;
    logic [W+3:0] acc_val;

    assign ch       = bus.io_in_bits;
    assign dsub     = ch - CH_0;
    assign in_ready = (state_q != EMIT);
    assign fire     = bus.io_in_valid && in_ready;
    assign field_ok = !acc_ovf && !acc_many;

    decimal_accumulator #(.W(W), .MAXDIG(MAXDIG)) u_acc (
        .clock             (clock),
        .reset             (reset),
        .clear_i           (acc_clr),
        .load_i            (acc_ld),
        .digit_i           (dsub[3:0]),
        .value_o           (acc_val),
        .overflow_o        (acc_ovf),
        .too_many_digits_o (acc_many)
    );

    always_comb begin
        state_d = state_q;
        pidx_d  = pidx_q;
        fidx_d  = fidx_q;
        sp_d    = sp_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        mm_d    = mm_q;
        err_d   = 1'b0;
        acc_clr = 1'b0;
        acc_ld  = 1'b0;
        bad     = 1'b0;
        case (state_q)
            PREFIX: if (fire) begin
                if (ch == PREFIX_ROM[pidx_q]) begin
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) begin
                        state_d = SEP;
                        fidx_d  = 2'd0;
                        sp_d    = 1'b0;
                    end
                end else if (!(ch == CH_NL && pidx_q == 2'd0)) begin
                    bad = 1'b1;
                end
            end
            SEP: if (fire) begin
                if (ch == CH_SPACE) begin
                    sp_d = 1'b1;
                end else if (is_digit(ch) && sp_q) begin
                    state_d = DIGIT;
                    acc_clr = 1'b1;
                    acc_ld  = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            DIGIT: if (fire) begin
                if (is_digit(ch)) begin
                    acc_ld = 1'b1;
                end else if (ch == CH_SPACE && fidx_q < 2'd2 && field_ok) begin
                    if (fidx_q == 2'd0) a_d = acc_val[W-1:0];
                    else                b_d = acc_val[W-1:0];
                    fidx_d  = fidx_q + 2'd1;
                    // The closing space already separates the next field.
                    sp_d    = 1'b1;
                    state_d = SEP;
                end else if (ch == CH_NL && fidx_q == 2'd2 && field_ok) begin
                    res_d   = acc_val[W-1:0];
                    mm_d    = acc_val[W-1:0] != (a_q & b_q);
                    state_d = EMIT;
                end else begin
                    bad = 1'b1;
                end
            end
            EMIT: if (bus.io_out_ready) begin
                state_d = PREFIX;
                pidx_d  = 2'd0;
            end
            DISCARD: if (fire && ch == CH_NL) begin
                state_d = PREFIX;
                pidx_d  = 2'd0;
            end
            default: state_d = PREFIX;
        endcase
        if (bad) begin
            err_d   = 1'b1;
            pidx_d  = 2'd0;
            state_d = (ch == CH_NL) ? PREFIX : DISCARD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PREFIX;
            pidx_q  <= '0;
            fidx_q  <= '0;
            sp_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            mm_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pidx_q  <= pidx_d;
            fidx_q  <= fidx_d;
            sp_q    <= sp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            mm_q    <= mm_d;
            err_q   <= err_d;
        end
    end

    assign bus.io_in_ready     = in_ready;
    assign bus.io_out_valid    = (state_q == EMIT);
    assign bus.io_out_a        = a_q;
    assign bus.io_out_b        = b_q;
    assign bus.io_out_res      = res_q;
    assign bus.io_out_mismatch = mm_q;
    assign bus.io_err          = err_q;
endmodule

// File: tb/tb_trace_line_parser.sv
// Directed bench for trace_line_parser: records, backpressure, errors, reset.
module tb_trace_line_parser;
    localparam int W = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   npass = 0;
    int   ntotal = 0;
    int   rec_cnt = 0;
    int   err_cnt = 0;
    int   vld_cyc = 0;

    trace_line_parser_if #(.W(W)) bus ();

    trace_line_parser #(.W(W), .MAXDIG(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (bus.io_out_valid) vld_cyc++;
            if (bus.io_out_valid && bus.io_out_ready) rec_cnt++;
            if (bus.io_err) err_cnt++;
        end
    end

    task automatic clr_counts();
        rec_cnt = 0;
        err_cnt = 0;
        vld_cyc = 0;
    endtask

    task automatic send_byte(input logic [7:0] c);
        bit done;
        done = 1'b0;
        bus.io_in_valid = 1'b1;
        bus.io_in_bits  = c;
        for (int t = 0; t < 50 && !done; t++) begin
            done = bus.io_in_ready;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            ntotal++;
            $display("FAIL send_timeout byte=%h never accepted", c);
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        bus.io_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.io_in_valid  = 1'b0;
        bus.io_in_bits   = 8'h00;
        bus.io_out_ready = 1'b1;
        reset = 1'b0;
        idle(2);
        ntotal++; if (bus.io_out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.io_out_valid); else npass++;
        ntotal++; if (bus.io_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.io_err); else npass++;
        ntotal++; if (bus.io_in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.io_in_ready); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== 7'd0)
            $display("FAIL reset_fields got=%b exp=0", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}); else npass++;
        @(negedge clock);
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        clr_counts();
        bus.io_out_ready = 1'b1;
        send_line("dut: 3 1 1\n");
        ntotal++; if (bus.io_out_valid !== 1'b1) $display("FAIL basic_latency valid=%b exp=1", bus.io_out_valid); else npass++;
        idle(3);
        ntotal++; if (rec_cnt !== 1) $display("FAIL basic_count got=%0d exp=1", rec_cnt); else npass++;
        ntotal++; if (vld_cyc !== 1) $display("FAIL basic_valid_cycles got=%0d exp=1", vld_cyc); else npass++;
        ntotal++; if (err_cnt !== 0) $display("FAIL basic_err got=%0d exp=0", err_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd3, 2'd1, 2'd1, 1'b0})
            $display("FAIL basic_fields got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd3, 2'd1, 2'd1, 1'b0}); else npass++;
    endtask

    task automatic test_mismatch();
        clr_counts();
        send_line("dut: 2 2 0\n");
        idle(3);
        ntotal++; if (rec_cnt !== 1) $display("FAIL mm_count got=%0d exp=1", rec_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd2, 2'd2, 2'd0, 1'b1})
            $display("FAIL mm_fields got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd2, 2'd2, 2'd0, 1'b1}); else npass++;
    endtask

    task automatic test_backpressure();
        clr_counts();
        bus.io_out_ready = 1'b0;
        send_line("dut:  1   3 1\n");
        for (int i = 0; i < 5; i++) begin
            ntotal++; if (bus.io_out_valid !== 1'b1 || bus.io_in_ready !== 1'b0)
                $display("FAIL bp_hold cyc=%0d valid=%b ready=%b exp valid=1 ready=0", i, bus.io_out_valid, bus.io_in_ready); else npass++;
            ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd1, 2'd3, 2'd1, 1'b0})
                $display("FAIL bp_fields cyc=%0d got=%b exp=%b", i, {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd1, 2'd3, 2'd1, 1'b0}); else npass++;
            idle(1);
        end
        ntotal++; if (rec_cnt !== 0) $display("FAIL bp_no_xfer got=%0d exp=0", rec_cnt); else npass++;
        bus.io_out_ready = 1'b1;
        send_line("dut: 0 3 2\n");
        idle(3);
        ntotal++; if (rec_cnt !== 2) $display("FAIL bp_release_count got=%0d exp=2", rec_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd0, 2'd3, 2'd2, 1'b1})
            $display("FAIL bp_next_fields got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd0, 2'd3, 2'd2, 1'b1}); else npass++;
    endtask

    task automatic test_bad_prefix();
        clr_counts();
        send_line("dux: 1 1 1\n");
        send_line("\n");
        send_line("dut: 1 1 1\n");
        send_line("\n");
        idle(3);
        ntotal++; if (err_cnt !== 1) $display("FAIL prefix_err got=%0d exp=1", err_cnt); else npass++;
        ntotal++; if (rec_cnt !== 1) $display("FAIL prefix_count got=%0d exp=1", rec_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd1, 2'd1, 2'd1, 1'b0})
            $display("FAIL prefix_fields got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd1, 2'd1, 2'd1, 1'b0}); else npass++;
    endtask

    task automatic test_field_errors();
        clr_counts();
        send_line("dut: 4 1 0\n");
        idle(3);
        ntotal++; if (err_cnt !== 1 || rec_cnt !== 0) $display("FAIL ovf err=%0d rec=%0d exp err=1 rec=0", err_cnt, rec_cnt); else npass++;
        clr_counts();
        send_line("dut: 0001 1 1\n");
        idle(3);
        ntotal++; if (err_cnt !== 1 || rec_cnt !== 0) $display("FAIL maxdig err=%0d rec=%0d exp err=1 rec=0", err_cnt, rec_cnt); else npass++;
        clr_counts();
        send_line("dut: 1 1\n");
        idle(3);
        ntotal++; if (err_cnt !== 1 || rec_cnt !== 0) $display("FAIL short err=%0d rec=%0d exp err=1 rec=0", err_cnt, rec_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd1, 2'd1, 2'd1, 1'b0})
            $display("FAIL err_keeps_out got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd1, 2'd1, 2'd1, 1'b0}); else npass++;
        // Three-digit value with leading zeros stays within MAXDIG.
        clr_counts();
        send_line("dut: 002 3 2\n");
        idle(3);
        ntotal++; if (err_cnt !== 0 || rec_cnt !== 1 || bus.io_out_a !== 2'd2 || bus.io_out_mismatch !== 1'b0)
            $display("FAIL three_digits err=%0d rec=%0d a=%0d mm=%b exp err=0 rec=1 a=2 mm=0", err_cnt, rec_cnt, bus.io_out_a, bus.io_out_mismatch); else npass++;
    endtask

    task automatic test_back_to_back();
        clr_counts();
        send_line("dut: 3 3 3\n");
        send_line("dut: 1 2 3\n");
        idle(3);
        ntotal++; if (rec_cnt !== 2 || err_cnt !== 0) $display("FAIL b2b rec=%0d err=%0d exp rec=2 err=0", rec_cnt, err_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd1, 2'd2, 2'd3, 1'b1})
            $display("FAIL b2b_fields got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd1, 2'd2, 2'd3, 1'b1}); else npass++;
    endtask

    task automatic test_mid_reset();
        clr_counts();
        send_line("dut: 3 ");
        reset = 1'b0;
        idle(2);
        @(negedge clock);
        reset = 1'b1;
        idle(3);
        ntotal++; if (rec_cnt !== 0 || err_cnt !== 0) $display("FAIL midrst rec=%0d err=%0d exp 0/0", rec_cnt, err_cnt); else npass++;
        send_line("dut: 1 0 0\n");
        idle(3);
        ntotal++; if (rec_cnt !== 1 || err_cnt !== 0) $display("FAIL midrst_after rec=%0d err=%0d exp rec=1 err=0", rec_cnt, err_cnt); else npass++;
        ntotal++; if ({bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch} !== {2'd1, 2'd0, 2'd0, 1'b0})
            $display("FAIL midrst_fields got=%b exp=%b", {bus.io_out_a, bus.io_out_b, bus.io_out_res, bus.io_out_mismatch}, {2'd1, 2'd0, 2'd0, 1'b0}); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_backpressure();
        test_bad_prefix();
        test_field_errors();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
